step_sequencer: RTL and testbench
=================================

Name: step_sequencer

Overview:
- Top-level timestep controller for the PIC loop.
- Drives the global `step` bus and issues start pulses to the scatter, field-solve (`full_solver`) and push engines, in that order, for a programmed number of timesteps.
- Collects each engine's done, counts completed timesteps and guards every phase with a watchdog timeout.
- Sits between the host/control interface and the three engines.

Parameters:
- `STEP_CNT_W`, 16, width of the timestep count and counter.
- `TIMEOUT_W`, 24, width of the per-phase watchdog counter; timeout fires at 2^TIMEOUT_W-1 cycles.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `run`  in  1  pulse: begin a run of `num_steps` timesteps (sampled only in IDLE)
- `abort`  in  1  pulse: abandon the run and return to IDLE
- `num_steps`  in  STEP_CNT_W  timesteps to execute; sampled with `run`
- `scatter_done`  in  1  level done from the scatter engine
- `solve_done`  in  1  level done from `full_solver`
- `push_done`  in  1  level done from the pusher
- `step`  out  step_t  current phase broadcast to all engines
- `scatter_start`  out  1  one-cycle start pulse
- `solve_start`  out  1  one-cycle start pulse
- `push_start`  out  1  one-cycle start pulse
- `busy`  out  1  high from `run` acceptance until return to IDLE
- `run_done`  out  1  one-cycle pulse when the last timestep completes
- `error`  out  1  sticky watchdog flag
- `steps_done`  out  STEP_CNT_W  completed timesteps in the current run

Behaviour:
- Reset values:
  - `step` = SCATTER
  - all start pulses = 0
  - `busy` = 0, `run_done` = 0, `error` = 0, `steps_done` = 0
  - internal `phase` = SCATTER, watchdog = 0, done-edge registers = 0
  - state = IDLE
- States:
  - IDLE: `busy`=0. On `run` with `num_steps`≠0: latch `num_steps`, clear `steps_done`, set `phase`=SCATTER, go to SETUP. `run` with `num_steps`=0: stay in IDLE and assert `run_done` for one cycle.
  - SETUP: one cycle. `step` is already driven with `phase`, so every engine sees `step` stable at least one cycle before its start pulse. Go to START.
  - START: assert the start pulse matching `phase` for exactly one cycle. Clear the watchdog. Go to WAIT.
  - WAIT: wait for a rising edge (0→1, registered previous value) of the done matching `phase`. The other done inputs are ignored. Done levels that are already high from an earlier run never complete a phase. On the edge, go to NEXT.
  - NEXT: one cycle.
    - SCATTER→SOLVE, SOLVE→PUSH, then go to SETUP.
    - PUSH: increment `steps_done`. If it now equals the latched count, pulse `run_done`, set `phase`=SCATTER and go to IDLE. Otherwise set `phase`=SCATTER and go to SETUP.
  - ERROR: entered from WAIT when the watchdog reaches 2^TIMEOUT_W-1 before the done edge. Sets `error`; `busy` stays 1 and no start pulses are issued. Left only by `abort` or `rst`.
- `step` output:
  - registered; equals `phase` in every state.
  - In IDLE it holds SCATTER, so `full_solver` BRAM address muxes stay in non-SOLVE mode.
- Latency: `run` to `scatter_start` is 2 cycles (IDLE→SETUP→START). Done edge to the next phase's start is 3 cycles (edge detect, NEXT, SETUP, then start in START).
- Watchdog: increments by 1 each cycle in WAIT only and saturates. Cleared in START.
- `abort`:
  - from any non-IDLE state: next cycle go to IDLE, `phase`=SCATTER, `busy`=0.
  - `error` is cleared; `steps_done` holds its value.
  - `abort` has priority over a done edge or timeout in the same cycle.
  - In IDLE, `abort` has priority over a simultaneous `run`.
- `run` outside IDLE is ignored.
- `rst` mid-run forces all reset values next cycle; no start pulse is emitted in that cycle.
- `steps_done` is not wrapped: `num_steps` ≤ 2^STEP_CNT_W-1 bounds it.

Test Plan:
- `num_steps`=2, each engine returns done 10 cycles after its start → start pulses in order S,V,P,S,V,P, each one cycle wide; `step` is stable ≥1 cycle before each pulse; `steps_done` goes 1 then 2; `run_done` pulses once; `busy` falls the same cycle.
- `solve_done` held high from the previous run when a new `run` is issued → SOLVE is not skipped; the sequencer waits for the new 0→1 edge.
- TIMEOUT_W=4, `push_done` never rises → `error`=1 exactly 15 cycles into WAIT; no further start pulses; `abort` → IDLE, `error`=0, `steps_done` holds its value.
- `abort` in the same cycle as a `solve_done` edge → IDLE; `push_start` is never asserted.
- `run` with `num_steps`=0 → `run_done` one cycle, `busy` stays 0, no start pulses; `run` while busy → ignored.
- `rst` asserted during WAIT(SOLVE) → next cycle `step`=SCATTER, all outputs at reset values; a subsequent `run` starts cleanly.

Source files
------------

// File: rtl/step_sequencer.sv
// Timestep controller for the PIC loop: sequences scatter, field solve and push
// for a programmed number of timesteps, with a per-phase watchdog.
package step_sequencer_pkg;
  typedef enum logic [1:0] {
    SCATTER = 2'd0,
    SOLVE   = 2'd1,
    PUSH    = 2'd2
  } step_t;
endpackage

module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int unsigned STEP_CNT_W = 16,
  parameter int unsigned TIMEOUT_W  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  abort,
  input  logic [STEP_CNT_W-1:0] num_steps,
  input  logic                  scatter_done,
  input  logic                  solve_done,
  input  logic                  push_done,
  output step_t                 step,
  output logic                  scatter_start,
  output logic                  solve_start,
  output logic                  push_start,
  output logic                  busy,
  output logic                  run_done,
  output logic                  error,
  output logic [STEP_CNT_W-1:0] steps_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_START,
    S_WAIT,
    S_NEXT,
    S_ERROR
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WD_MAX  = '1;
  localparam logic [TIMEOUT_W-1:0] WD_LAST = WD_MAX - TIMEOUT_W'(1);

  state_t                  state;
  step_t                   phase;
  logic [TIMEOUT_W-1:0]    wd;
  logic [STEP_CNT_W-1:0]   target;
  logic                    scatter_prev;
  logic                    solve_prev;
  logic                    push_prev;
  logic                    done_sel_c;
  logic                    prev_sel_c;
  logic                    done_edge_c;
  logic [STEP_CNT_W-1:0]   steps_inc_c;

  // The phase register is the broadcast step bus; it holds SCATTER while idle.
  assign step = phase;

  assign steps_inc_c = steps_done + STEP_CNT_W'(1);

  // Only the done belonging to the current phase can complete it, and only on a 0->1 edge.
  always_comb begin
    done_sel_c = 1'b0;
    prev_sel_c = 1'b0;
    case (phase)
      SCATTER: begin
        done_sel_c = scatter_done;
        prev_sel_c = scatter_prev;
      end
      SOLVE: begin
        done_sel_c = solve_done;
        prev_sel_c = solve_prev;
      end
      PUSH: begin
        done_sel_c = push_done;
        prev_sel_c = push_prev;
      end
      default: begin
        done_sel_c = 1'b0;
        prev_sel_c = 1'b0;
      end
    endcase
    done_edge_c = done_sel_c & ~prev_sel_c;
  end

  // Sequencer state, phase, watchdog and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      phase         <= SCATTER;
      wd            <= '0;
      target        <= '0;
      scatter_prev  <= 1'b0;
      solve_prev    <= 1'b0;
      push_prev     <= 1'b0;
      scatter_start <= 1'b0;
      solve_start   <= 1'b0;
      push_start    <= 1'b0;
      busy          <= 1'b0;
      run_done      <= 1'b0;
      error         <= 1'b0;
      steps_done    <= '0;
    end else begin
      scatter_prev  <= scatter_done;
      solve_prev    <= solve_done;
      push_prev     <= push_done;
      scatter_start <= 1'b0;
      solve_start   <= 1'b0;
      push_start    <= 1'b0;
      run_done      <= 1'b0;

      if (abort) begin
        // Abort wins over run, done edges and timeouts; steps_done is kept for inspection.
        state <= S_IDLE;
        phase <= SCATTER;
        busy  <= 1'b0;
        error <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (run) begin
              if (num_steps != '0) begin
                target     <= num_steps;
                steps_done <= '0;
                phase      <= SCATTER;
                busy       <= 1'b1;
                state      <= S_SETUP;
              end else begin
                run_done <= 1'b1;
              end
            end
          end
          S_SETUP: begin
            // step has been stable for a cycle; the pulse is visible in START.
            case (phase)
              SCATTER: scatter_start <= 1'b1;
              SOLVE:   solve_start   <= 1'b1;
              PUSH:    push_start    <= 1'b1;
              default: scatter_start <= 1'b0;
            endcase
            state <= S_START;
          end
          S_START: begin
            wd    <= '0;
            state <= S_WAIT;
          end
          S_WAIT: begin
            wd <= (wd == WD_MAX) ? wd : wd + TIMEOUT_W'(1);
            if (done_edge_c) begin
              state <= S_NEXT;
            end else if (wd == WD_LAST) begin
              error <= 1'b1;
              state <= S_ERROR;
            end
          end
          S_NEXT: begin
            case (phase)
              SCATTER: begin
                phase <= SOLVE;
                state <= S_SETUP;
              end
              SOLVE: begin
                phase <= PUSH;
                state <= S_SETUP;
              end
              default: begin
                steps_done <= steps_inc_c;
                phase      <= SCATTER;
                if (steps_inc_c == target) begin
                  run_done <= 1'b1;
                  busy     <= 1'b0;
                  state    <= S_IDLE;
                end else begin
                  state <= S_SETUP;
                end
              end
            endcase
          end
          S_ERROR: begin
            state <= S_ERROR;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed vector table, hand-written corner sequences
// and randomized runs checked against a cycle-timeline model.
module tb_step_sequencer;
  import step_sequencer_pkg::*;

  localparam int unsigned SW = 16;
  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          abort;
  logic [SW-1:0] num_steps;
  logic          scatter_done;
  logic          solve_done;
  logic          push_done;
  step_t         step;
  logic          scatter_start;
  logic          solve_start;
  logic          push_start;
  logic          busy;
  logic          run_done;
  logic          error;
  logic [SW-1:0] steps_done;

  // Done sources: manual levels or an automatic engine responder.
  logic       auto_en;
  logic [2:0] m_done;
  logic [2:0] a_done = 3'b000;
  int         a_cnt[3] = '{0, 0, 0};
  int         dly[3];
  logic [2:0] st_v;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign scatter_done = auto_en ? a_done[0] : m_done[0];
  assign solve_done   = auto_en ? a_done[1] : m_done[1];
  assign push_done    = auto_en ? a_done[2] : m_done[2];
  assign st_v         = {push_start, solve_start, scatter_start};

  step_sequencer #(.STEP_CNT_W(SW), .TIMEOUT_W(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .abort        (abort),
    .num_steps    (num_steps),
    .scatter_done (scatter_done),
    .solve_done   (solve_done),
    .push_done    (push_done),
    .step         (step),
    .scatter_start(scatter_start),
    .solve_start  (solve_start),
    .push_start   (push_start),
    .busy         (busy),
    .run_done     (run_done),
    .error        (error),
    .steps_done   (steps_done)
  );

  // Engine model: drop done on start, raise it dly cycles later (dly 0 = never).
  always @(negedge clk) begin
    for (int e = 0; e < 3; e++) begin
      if (st_v[e]) begin
        a_done[e] = 1'b0;
        a_cnt[e]  = dly[e];
      end else if (a_cnt[e] > 0) begin
        a_cnt[e] = a_cnt[e] - 1;
        if (a_cnt[e] == 0) a_done[e] = 1'b1;
      end
    end
  end

  typedef struct {
    logic          rst;
    logic          run;
    logic          abort;
    logic [SW-1:0] ns;
    logic [2:0]    dn;
    logic [31:0]   exp;
  } vec_t;

  vec_t tbl[20];

  function automatic logic [31:0] exp_v(input int st, input int stv, input int bz,
                                        input int rd, input int er, input int sd);
    return {8'd0, 2'(st), 3'(stv), 1'(bz), 1'(rd), 1'(er), 16'(sd)};
  endfunction

  function automatic logic [31:0] got_v();
    return {8'd0, 2'(step), push_start, solve_start, scatter_start, busy, run_done, error, steps_done};
  endfunction

  function automatic vec_t mk(input int r, input int ru, input int ab, input int ns,
                              input int dn, input logic [31:0] ex);
    vec_t v;
    v.rst   = 1'(r);
    v.run   = 1'(ru);
    v.abort = 1'(ab);
    v.ns    = 16'(ns);
    v.dn    = 3'(dn);
    v.exp   = ex;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic bit sig(input int which);
    case (which)
      0:       return scatter_start;
      1:       return solve_start;
      2:       return push_start;
      3:       return steps_done == 16'd1;
      default: return run_done;
    endcase
  endfunction

  // Bounded wait; waited = cycles until the event, or -1 if it never came.
  task automatic wait_sig(input int which, input int limit, output int waited);
    waited = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (sig(which)) begin
        waited = k;
        break;
      end
    end
  endtask

  // Watch for any start pulse over n cycles.
  task automatic watch_starts(input int n, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (st_v != 3'b000) seen = 1'b1;
    end
  endtask

  // Randomized run checked every cycle against a timeline computed from the phase delays.
  task automatic model_run(input int n, input bit spurious);
    int d[12];
    int s[12];
    int e[12];
    int np;
    int endc;
    np = 3 * n;
    for (int i = 0; i < np; i++) d[i] = int'($urandom_range(1, 15));
    s[0] = 1;
    for (int i = 0; i < np; i++) begin
      e[i] = s[i] + d[i] + 2;
      if (i + 1 < np) s[i+1] = s[i] + d[i] + 3;
    end
    endc = e[np-1];
    auto_en   = 1'b0;
    run       = 1'b1;
    num_steps = 16'(n);
    for (int c = 0; c <= endc + 2; c++) begin
      int         j;
      int         sd;
      logic [2:0] stv;
      j   = 0;
      sd  = 0;
      stv = 3'b000;
      tick();
      for (int i = 0; i < np; i++) begin
        if (e[i] <= c) begin
          j++;
          if (i % 3 == 2) sd++;
        end
        if (s[i] == c) stv[i%3] = 1'b1;
      end
      chk($sformatf("rand_n%0d_c%0d", n, c), got_v(),
          exp_v(j % 3, int'(stv), int'(c < endc), int'(c == endc), 0, sd));
      run       = spurious && (c < endc) && ($urandom_range(0, 7) == 0);
      num_steps = 16'($urandom);
      for (int i = 0; i < np; i++) begin
        if (s[i] == c) m_done[i%3] = 1'b0;
        if (s[i] + d[i] == c) m_done[i%3] = 1'b1;
      end
    end
    run = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    int w;
    bit seen;
    auto_en   = 1'b0;
    rst       = 1'b1;
    run       = 1'b0;
    abort     = 1'b0;
    num_steps = '0;
    m_done    = 3'b000;
    dly       = '{1, 1, 1};

    // Single-step run, zero-step run, abort vs run, run while busy, abort mid-run.
    tbl[0]  = mk(1, 0, 0, 0, 'b000, exp_v(0, 'b000, 0, 0, 0, 0));
    tbl[1]  = mk(0, 1, 0, 0, 'b000, exp_v(0, 'b000, 0, 1, 0, 0));
    tbl[2]  = mk(0, 0, 0, 0, 'b000, exp_v(0, 'b000, 0, 0, 0, 0));
    tbl[3]  = mk(0, 1, 1, 3, 'b000, exp_v(0, 'b000, 0, 0, 0, 0));
    tbl[4]  = mk(0, 1, 0, 1, 'b000, exp_v(0, 'b000, 1, 0, 0, 0));
    tbl[5]  = mk(0, 1, 0, 5, 'b000, exp_v(0, 'b001, 1, 0, 0, 0));
    tbl[6]  = mk(0, 0, 0, 0, 'b000, exp_v(0, 'b000, 1, 0, 0, 0));
    tbl[7]  = mk(0, 0, 0, 0, 'b001, exp_v(0, 'b000, 1, 0, 0, 0));
    tbl[8]  = mk(0, 0, 0, 0, 'b001, exp_v(1, 'b000, 1, 0, 0, 0));
    tbl[9]  = mk(0, 0, 0, 0, 'b001, exp_v(1, 'b010, 1, 0, 0, 0));
    tbl[10] = mk(0, 0, 0, 0, 'b001, exp_v(1, 'b000, 1, 0, 0, 0));
    tbl[11] = mk(0, 0, 0, 0, 'b011, exp_v(1, 'b000, 1, 0, 0, 0));
    tbl[12] = mk(0, 0, 0, 0, 'b011, exp_v(2, 'b000, 1, 0, 0, 0));
    tbl[13] = mk(0, 0, 0, 0, 'b011, exp_v(2, 'b100, 1, 0, 0, 0));
    tbl[14] = mk(0, 0, 0, 0, 'b011, exp_v(2, 'b000, 1, 0, 0, 0));
    tbl[15] = mk(0, 0, 0, 0, 'b111, exp_v(2, 'b000, 1, 0, 0, 0));
    tbl[16] = mk(0, 0, 0, 0, 'b111, exp_v(0, 'b000, 0, 1, 0, 1));
    tbl[17] = mk(0, 0, 0, 0, 'b111, exp_v(0, 'b000, 0, 0, 0, 1));
    tbl[18] = mk(0, 1, 0, 2, 'b111, exp_v(0, 'b000, 1, 0, 0, 0));
    tbl[19] = mk(0, 0, 1, 0, 'b111, exp_v(0, 'b000, 0, 0, 0, 0));

    for (int i = 0; i < 20; i++) begin
      rst       = tbl[i].rst;
      run       = tbl[i].run;
      abort     = tbl[i].abort;
      num_steps = tbl[i].ns;
      m_done    = tbl[i].dn;
      tick();
      chk($sformatf("vec%0d", i), got_v(), tbl[i].exp);
    end
    run   = 1'b0;
    abort = 1'b0;
    tick();

    // solve_done held high from before: the solve phase must wait for a fresh rise.
    m_done    = 3'b010;
    run       = 1'b1;
    num_steps = 16'd1;
    tick();
    run = 1'b0;
    wait_sig(0, 10, w);
    chk("held_scatter_start", 32'(w), 32'd1);
    tick();
    m_done[0] = 1'b1;
    wait_sig(1, 10, w);
    chk("held_done_to_solve_start", 32'(w), 32'd3);
    watch_starts(8, seen);
    chk("held_no_solve_skip", 32'(seen), 32'd0);
    chk("held_still_busy", 32'(busy), 32'd1);
    m_done[1] = 1'b0;
    tick();
    m_done[1] = 1'b1;
    wait_sig(2, 10, w);
    chk("held_new_edge_to_push_start", 32'(w), 32'd3);
    tick();
    m_done[2] = 1'b1;
    wait_sig(4, 10, w);
    chk("held_push_edge_to_run_done", 32'(w), 32'd2);
    chk("held_final", got_v(), exp_v(0, 'b000, 0, 1, 0, 1));

    // Watchdog: second push never completes.
    auto_en   = 1'b1;
    dly       = '{3, 3, 3};
    run       = 1'b1;
    num_steps = 16'd2;
    tick();
    run = 1'b0;
    wait_sig(3, 80, w);
    chk("wd_first_step_done", 32'(w > 0), 32'd1);
    dly[2] = 0;
    wait_sig(2, 80, w);
    chk("wd_second_push_start", 32'(w > 0), 32'd1);
    repeat (15) tick();
    chk("wd_error_low_before_limit", 32'(error), 32'd0);
    tick();
    chk("wd_error_at_limit", got_v(), exp_v(2, 'b000, 1, 0, 1, 1));
    watch_starts(8, seen);
    chk("wd_no_starts_in_error", 32'(seen), 32'd0);
    chk("wd_error_sticky", 32'(error), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("wd_abort_to_idle", got_v(), exp_v(0, 'b000, 0, 0, 0, 1));

    // Abort coinciding with the solve_done edge: push must never start.
    dly       = '{2, 4, 2};
    run       = 1'b1;
    num_steps = 16'd1;
    tick();
    run = 1'b0;
    wait_sig(1, 40, w);
    chk("ab_solve_start", 32'(w > 0), 32'd1);
    repeat (4) tick();
    abort = 1'b1;
    #1;
    chk("ab_solve_done_same_cycle", 32'(solve_done), 32'd1);
    tick();
    abort = 1'b0;
    chk("ab_idle", got_v(), exp_v(0, 'b000, 0, 0, 0, 0));
    watch_starts(20, seen);
    chk("ab_no_push_start", 32'(seen), 32'd0);

    // Reset while waiting on the solver, then a clean run.
    dly       = '{2, 0, 2};
    run       = 1'b1;
    num_steps = 16'd3;
    tick();
    run = 1'b0;
    wait_sig(1, 40, w);
    chk("rst_solve_start", 32'(w > 0), 32'd1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_run", got_v(), exp_v(0, 'b000, 0, 0, 0, 0));
    rst     = 1'b0;
    auto_en = 1'b0;
    m_done  = 3'b000;
    tick();
    chk("rst_idle_after", got_v(), exp_v(0, 'b000, 0, 0, 0, 0));
    model_run(2, 1'b0);

    // Randomized runs; odd runs also pulse run while busy.
    for (int r = 0; r < 15; r++) begin
      model_run(int'($urandom_range(1, 4)), 1'(r % 2));
      repeat (int'($urandom_range(0, 3))) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
